// File: rtl/mem_arb_pkg.sv
// Shared definitions for the multi-port memory arbiter: arbitration modes
// and the packed request-entry width {wr, address, data}.
package mem_arb_pkg;

  localparam int ARB_ROUND_ROBIN = 0;
  localparam int ARB_FIXED       = 1;

  function automatic int entry_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/arb_request_fifo.sv
// Per-port synchronous request FIFO with first-word fall-through read data
// and a registered occupancy count.
module arb_request_fifo #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = store[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/multi_port_memory_arbiter.sv
// N-port request arbiter in front of a single-port word memory: per-port FIFOs,
// one grant per clock, a registered issue stage, then memory access and response.
module multi_port_memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int PERIPHERALS   = 2,
  parameter int ADDRESS_WIDTH = 14,
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int ARB_MODE      = ARB_ROUND_ROBIN
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [ADDRESS_WIDTH*PERIPHERALS-1:0] address,
  input  logic [PERIPHERALS-1:0]              wr,
  input  logic [DATA_WIDTH*PERIPHERALS-1:0]   data_in,
  input  logic [PERIPHERALS-1:0]              data_in_ready,
  output logic [PERIPHERALS-1:0]              fifo_full,
  output logic [PERIPHERALS-1:0]              overflow,
  output logic [DATA_WIDTH-1:0]               data_out,
  output logic [PERIPHERALS-1:0]              data_out_ready
);

  localparam int EW = entry_width(ADDRESS_WIDTH, DATA_WIDTH);
  localparam int IW = (PERIPHERALS > 1) ? $clog2(PERIPHERALS) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [EW-1:0]            fifo_rdata [PERIPHERALS];
  logic [CW-1:0]            fifo_count [PERIPHERALS];
  logic [PERIPHERALS-1:0]   fifo_empty;
  logic [PERIPHERALS-1:0]   fifo_at_cap;
  logic [PERIPHERALS-1:0]   push;
  logic [PERIPHERALS-1:0]   pop;
  logic                     grant_vld;
  logic [IW-1:0]            grant_id;
  logic [IW-1:0]            last_grant;
  logic [EW-1:0]            grant_entry;
  logic                     vld_p1;
  logic                     wr_p1;
  logic [ADDRESS_WIDTH-1:0] addr_p1;
  logic [DATA_WIDTH-1:0]    data_p1;
  logic [IW-1:0]            id_p1;
  logic [DATA_WIDTH-1:0]    mem [2**ADDRESS_WIDTH];

  // Stage 0: per-port request queues; a strobe seen while full is dropped.
  for (genvar g = 0; g < PERIPHERALS; g++) begin : g_port
    assign push[g]      = data_in_ready[g] & ~fifo_at_cap[g];
    assign fifo_full[g] = (fifo_count[g] == CW'(FIFO_DEPTH));

    arb_request_fifo #(
      .WIDTH(EW),
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk  (clk),
      .reset_n(reset_n),
      .push (push[g]),
      .pop  (pop[g]),
      .wdata({wr[g], address[g*ADDRESS_WIDTH +: ADDRESS_WIDTH], data_in[g*DATA_WIDTH +: DATA_WIDTH]}),
      .rdata(fifo_rdata[g]),
      .count(fifo_count[g]),
      .full (fifo_at_cap[g]),
      .empty(fifo_empty[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= '0;
    end else begin
      overflow <= overflow | (data_in_ready & fifo_at_cap);
    end
  end

  // Loops run from the far end so the nearest eligible port is the last write.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    pop       = '0;
    if (ARB_MODE == ARB_FIXED) begin
      for (int k = PERIPHERALS - 1; k >= 0; k--) begin
        if (!fifo_empty[IW'(k)]) begin
          grant_vld = 1'b1;
          grant_id  = IW'(k);
        end
      end
    end else begin
      for (int k = PERIPHERALS; k >= 1; k--) begin
        if (!fifo_empty[IW'((int'(last_grant) + k) % PERIPHERALS)]) begin
          grant_vld = 1'b1;
          grant_id  = IW'((int'(last_grant) + k) % PERIPHERALS);
        end
      end
    end
    pop[grant_id] = grant_vld;
  end

  assign grant_entry = fifo_rdata[grant_id];

  // Stage 1: granted entry registered into the issue stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= IW'(PERIPHERALS - 1);
      vld_p1     <= 1'b0;
    end else begin
      if (grant_vld) last_grant <= grant_id;
      vld_p1 <= grant_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (grant_vld) begin
      {wr_p1, addr_p1, data_p1} <= grant_entry;
      id_p1                     <= grant_id;
    end
  end

  // Stage 2: memory access; reads return data with a one-hot owner strobe.
  always_ff @(posedge clk) begin
    if (vld_p1 && wr_p1) mem[addr_p1] <= data_p1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out       <= '0;
      data_out_ready <= '0;
    end else begin
      data_out_ready <= '0;
      if (vld_p1 && !wr_p1) begin
        data_out       <= mem[addr_p1];
        data_out_ready <= PERIPHERALS'(1) << id_p1;
      end
    end
  end

endmodule

// File: tb/tb_multi_port_memory_arbiter.sv
// Self-checking bench: a round-robin and a fixed-priority instance share stimulus
// and are compared against a queue-based reference model of the arbiter.
module tb_multi_port_memory_arbiter;

  localparam int P  = 2;
  localparam int AW = 14;
  localparam int DW = 8;
  localparam int FD = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [P*AW-1:0] address;
  logic [P-1:0]    wr;
  logic [P*DW-1:0] data_in;
  logic [P-1:0]    data_in_ready;

  logic [P-1:0]    full_rr, ovf_rr, rdy_rr;
  logic [DW-1:0]   dout_rr;
  logic [P-1:0]    full_fx, ovf_fx, rdy_fx;
  logic [DW-1:0]   dout_fx;

  logic [P-1:0]    act_rdy  [2];
  logic [DW-1:0]   act_dout [2];

  int checks   = 0;
  int failures = 0;

  multi_port_memory_arbiter #(
    .PERIPHERALS(P), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .ARB_MODE(0)
  ) dut_rr (
    .clk(clk), .reset_n(reset_n), .address(address), .wr(wr), .data_in(data_in),
    .data_in_ready(data_in_ready), .fifo_full(full_rr), .overflow(ovf_rr),
    .data_out(dout_rr), .data_out_ready(rdy_rr)
  );

  multi_port_memory_arbiter #(
    .PERIPHERALS(P), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .ARB_MODE(1)
  ) dut_fx (
    .clk(clk), .reset_n(reset_n), .address(address), .wr(wr), .data_in(data_in),
    .data_in_ready(data_in_ready), .fifo_full(full_fx), .overflow(ovf_fx),
    .data_out(dout_fx), .data_out_ready(rdy_fx)
  );

  assign act_rdy[0]  = rdy_rr;
  assign act_rdy[1]  = rdy_fx;
  assign act_dout[0] = dout_rr;
  assign act_dout[1] = dout_fx;

  always #5 clk = ~clk;

  // Reference model: index 0 = round-robin instance, index 1 = fixed priority.
  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  req_t          mq [2][P][$];
  logic [DW-1:0] mmem [2][2**AW];
  bit            iv [2];
  req_t          ie [2];
  int            iid [2];
  int            mlast [2];
  logic [P-1:0]  exp_rdy [2];
  logic [P-1:0]  exp_full [2];
  logic [P-1:0]  exp_ovf [2];
  logic [DW-1:0] exp_dout [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int p = 0; p < P; p++) mq[m][p].delete();
      iv[m]       = 1'b0;
      mlast[m]    = P - 1;
      exp_rdy[m]  = '0;
      exp_full[m] = '0;
      exp_ovf[m]  = '0;
      exp_dout[m] = '0;
    end
  endtask

  task automatic model_step(input logic [P-1:0] stb, input logic [P-1:0] w,
                            input logic [P*AW-1:0] a, input logic [P*DW-1:0] d);
    for (int m = 0; m < 2; m++) begin
      int pre [P];
      int g;
      for (int p = 0; p < P; p++) pre[p] = mq[m][p].size();
      exp_rdy[m] = '0;
      if (iv[m]) begin
        if (ie[m].wr) mmem[m][ie[m].addr] = ie[m].data;
        else begin
          exp_rdy[m][iid[m]] = 1'b1;
          exp_dout[m]        = mmem[m][ie[m].addr];
        end
      end
      iv[m] = 1'b0;
      g = -1;
      for (int k = 0; k < P; k++) begin
        int p;
        p = (m == 0) ? (mlast[m] + 1 + k) % P : k;
        if (g < 0 && pre[p] > 0) g = p;
      end
      if (g >= 0) begin
        ie[m]    = mq[m][g].pop_front();
        iid[m]   = g;
        iv[m]    = 1'b1;
        mlast[m] = g;
      end
      for (int p = 0; p < P; p++) begin
        if (stb[p]) begin
          if (pre[p] == FD) exp_ovf[m][p] = 1'b1;
          else mq[m][p].push_back('{w[p], a[p*AW +: AW], d[p*DW +: DW]});
        end
      end
      for (int p = 0; p < P; p++) exp_full[m][p] = (mq[m][p].size() == FD);
    end
  endtask

  task automatic cycle(input logic [P-1:0] stb, input logic [P-1:0] w,
                       input logic [P*AW-1:0] a, input logic [P*DW-1:0] d);
    data_in_ready = stb;
    wr            = w;
    address       = a;
    data_in       = d;
    @(posedge clk);
    model_step(stb, w, a, d);
    #1;
    data_in_ready = '0;
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    data_in_ready = '0;
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  function automatic logic [P*AW-1:0] a2(input logic [AW-1:0] a1, input logic [AW-1:0] a0);
    return {a1, a0};
  endfunction

  task automatic test_reset();
    reset_n       = 1'b0;
    data_in_ready = '0;
    wr            = '0;
    address       = '0;
    data_in       = '0;
    model_reset();
    #2;
    checks++;
    if ({full_rr, ovf_rr, dout_rr, rdy_rr} !== '0) begin
      failures++;
      $display("FAIL reset_rr: full=%b ovf=%b dout=%h rdy=%b, required all zero", full_rr, ovf_rr, dout_rr, rdy_rr);
    end
    checks++;
    if ({full_fx, ovf_fx, dout_fx, rdy_fx} !== '0) begin
      failures++;
      $display("FAIL reset_fx: full=%b ovf=%b dout=%h rdy=%b, required all zero", full_fx, ovf_fx, dout_fx, rdy_fx);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_single_read();
    int            lat;
    logic [P-1:0]  got_rdy;
    logic [DW-1:0] got_dout;
    do_reset();
    cycle(2'b01, 2'b01, a2(14'h0, 14'h0010), {8'h00, 8'hA5});
    repeat (3) cycle('0, '0, '0, '0);
    cycle(2'b01, 2'b00, a2(14'h0, 14'h0010), '0);
    lat = -1;
    for (int i = 1; i <= 6; i++) begin
      cycle('0, '0, '0, '0);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (act_rdy[m] !== exp_rdy[m] || act_dout[m] !== exp_dout[m]) begin
          failures++;
          $display("FAIL single_read_model m%0d: rdy=%b dout=%h, expected rdy=%b dout=%h",
                   m, act_rdy[m], act_dout[m], exp_rdy[m], exp_dout[m]);
        end
      end
      if (lat < 0 && rdy_rr !== 2'b00) begin
        lat      = i;
        got_rdy  = rdy_rr;
        got_dout = dout_rr;
      end
    end
    checks++;
    if (lat != 2) begin
      failures++;
      $display("FAIL single_read_latency: response after edge %0d past strobe, required 2", lat);
    end
    checks++;
    if (got_rdy !== 2'b01 || got_dout !== 8'hA5) begin
      failures++;
      $display("FAIL single_read_data: rdy=%b dout=%h, required rdy=01 dout=a5", got_rdy, got_dout);
    end
  endtask

  task automatic test_write_then_read();
    bit            found;
    logic [P-1:0]  got_rdy;
    logic [DW-1:0] got_dout;
    do_reset();
    cycle(2'b10, 2'b10, a2(14'h1FFF, 14'h0), {8'h3C, 8'h00});
    cycle(2'b10, 2'b00, a2(14'h1FFF, 14'h0), '0);
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle('0, '0, '0, '0);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (act_rdy[m] !== exp_rdy[m] || act_dout[m] !== exp_dout[m]) begin
          failures++;
          $display("FAIL wr_rd_model m%0d: rdy=%b dout=%h, expected rdy=%b dout=%h",
                   m, act_rdy[m], act_dout[m], exp_rdy[m], exp_dout[m]);
        end
      end
      if (!found && rdy_rr !== 2'b00) begin
        found    = 1'b1;
        got_rdy  = rdy_rr;
        got_dout = dout_rr;
      end
    end
    checks++;
    if (!found || got_rdy !== 2'b10 || got_dout !== 8'h3C) begin
      failures++;
      $display("FAIL wr_rd_data: found=%0d rdy=%b dout=%h, required rdy=10 dout=3c", found, got_rdy, got_dout);
    end
  endtask

  task automatic preload();
    for (int i = 0; i < 8; i++) begin
      cycle(2'b01, 2'b01, a2(14'h0, 14'h100 + 14'(i)), {8'h00, 8'($urandom_range(255))});
      cycle(2'b10, 2'b10, a2(14'h200 + 14'(i), 14'h0), {8'($urandom_range(255)), 8'h00});
    end
    repeat (4) cycle('0, '0, '0, '0);
  endtask

  task automatic test_round_robin();
    int seq [$];
    int exp_n;
    do_reset();
    preload();
    exp_n = 0;
    for (int i = 0; i < 20; i++) begin
      if (i < 8) cycle(2'b11, 2'b00, a2(14'h200 + 14'(i), 14'h100 + 14'(i)), '0);
      else cycle('0, '0, '0, '0);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (act_rdy[m] !== exp_rdy[m] || act_dout[m] !== exp_dout[m]) begin
          failures++;
          $display("FAIL rr_model m%0d cyc%0d: rdy=%b dout=%h, expected rdy=%b dout=%h",
                   m, i, act_rdy[m], act_dout[m], exp_rdy[m], exp_dout[m]);
        end
      end
      if (rdy_rr !== 2'b00) seq.push_back((rdy_rr == 2'b10) ? 1 : 0);
      if (exp_rdy[0] !== 2'b00) exp_n++;
    end
    checks++;
    if (seq.size() != exp_n || seq.size() < 8) begin
      failures++;
      $display("FAIL rr_count: %0d responses, required %0d (at least 8)", seq.size(), exp_n);
    end
    for (int k = 0; k < seq.size(); k++) begin
      checks++;
      if (seq[k] != k % 2) begin
        failures++;
        $display("FAIL rr_order: response %0d from port %0d, required port %0d", k, seq[k], k % 2);
      end
    end
  endtask

  task automatic test_fixed_priority();
    int seq [$];
    do_reset();
    for (int i = 0; i < 14; i++) begin
      if (i < 3) cycle(2'b11, 2'b00, a2(14'h200 + 14'(i), 14'h100 + 14'(i)), '0);
      else cycle('0, '0, '0, '0);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (act_rdy[m] !== exp_rdy[m] || act_dout[m] !== exp_dout[m]) begin
          failures++;
          $display("FAIL fixed_model m%0d cyc%0d: rdy=%b dout=%h, expected rdy=%b dout=%h",
                   m, i, act_rdy[m], act_dout[m], exp_rdy[m], exp_dout[m]);
        end
      end
      if (rdy_fx !== 2'b00) seq.push_back((rdy_fx == 2'b10) ? 1 : 0);
    end
    checks++;
    if (seq.size() != 6) begin
      failures++;
      $display("FAIL fixed_count: %0d responses, required 6", seq.size());
    end
    for (int k = 0; k < seq.size(); k++) begin
      checks++;
      if (seq[k] != ((k < 3) ? 0 : 1)) begin
        failures++;
        $display("FAIL fixed_order: response %0d from port %0d, required port %0d", k, seq[k], (k < 3) ? 0 : 1);
      end
    end
  endtask

  task automatic test_overflow();
    int n0, n1;
    do_reset();
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 22; i++) begin
      if (i < 8) cycle({1'(i < 5), 1'b1}, 2'b00, a2(14'h200 + 14'(i), 14'h100 + 14'(i)), '0);
      else cycle('0, '0, '0, '0);
      checks++;
      if (rdy_fx !== exp_rdy[1] || dout_fx !== exp_dout[1] || full_fx !== exp_full[1] || ovf_fx !== exp_ovf[1]) begin
        failures++;
        $display("FAIL ovf_model cyc%0d: rdy=%b dout=%h full=%b ovf=%b, expected rdy=%b dout=%h full=%b ovf=%b",
                 i, rdy_fx, dout_fx, full_fx, ovf_fx, exp_rdy[1], exp_dout[1], exp_full[1], exp_ovf[1]);
      end
      if (i == 3) begin
        checks++;
        if (full_fx[1] !== 1'b1 || ovf_fx[1] !== 1'b0) begin
          failures++;
          $display("FAIL ovf_fill: full1=%b ovf1=%b after 4 strobes, required full1=1 ovf1=0", full_fx[1], ovf_fx[1]);
        end
      end
      if (i == 4) begin
        checks++;
        if (full_fx[1] !== 1'b1 || ovf_fx !== 2'b10) begin
          failures++;
          $display("FAIL ovf_drop: full1=%b ovf=%b after 5th strobe, required full1=1 ovf=10", full_fx[1], ovf_fx);
        end
      end
      if (rdy_fx == 2'b01) n0++;
      if (rdy_fx == 2'b10) n1++;
    end
    checks++;
    if (n1 != 4 || n0 != 8) begin
      failures++;
      $display("FAIL ovf_responses: port0=%0d port1=%0d, required port0=8 port1=4", n0, n1);
    end
  endtask

  task automatic test_mid_reset();
    bit            found;
    logic [DW-1:0] got_dout;
    do_reset();
    for (int i = 0; i < 3; i++) cycle(2'b01, 2'b00, a2(14'h0, 14'h0010), '0);
    reset_n = 1'b0;
    model_reset();
    #2;
    checks++;
    if ({full_rr, ovf_rr, dout_rr, rdy_rr, full_fx, ovf_fx, dout_fx, rdy_fx} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: rr dout=%h rdy=%b fx dout=%h rdy=%b, required all zero",
               dout_rr, rdy_rr, dout_fx, rdy_fx);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle('0, '0, '0, '0);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (act_rdy[m] !== 2'b00 || act_dout[m] !== 8'h00) begin
          failures++;
          $display("FAIL midreset_quiet m%0d cyc%0d: rdy=%b dout=%h, required rdy=00 dout=00",
                   m, i, act_rdy[m], act_dout[m]);
        end
      end
    end
    cycle(2'b01, 2'b00, a2(14'h0, 14'h0010), '0);
    found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle('0, '0, '0, '0);
      if (!found && rdy_fx === 2'b01) begin
        found    = 1'b1;
        got_dout = dout_fx;
      end
    end
    checks++;
    if (!found || got_dout !== 8'hA5) begin
      failures++;
      $display("FAIL midreset_mem: found=%0d dout=%h, required response with dout=a5", found, got_dout);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_then_read();
    test_round_robin();
    test_fixed_priority();
    test_overflow();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multi_port_memory_arbiter.md
MULTI_PORT_MEMORY_ARBITER -- requirements
Module: multi_port_memory_arbiter

Interface
REQ-001 SHALL have parameter PERIPHERALS, default 2: number of requesting ports, range 1..8.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 14: word address width; memory depth is 2**ADDRESS_WIDTH.
REQ-003 SHALL have parameter DATA_WIDTH, default 8: memory word width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: per-port request FIFO entries, power of two, 2..64.
REQ-005 SHALL have parameter ARB_MODE, default 0: 0 = round-robin, 1 = fixed priority with port 0 highest.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port address, input, ADDRESS_WIDTH*PERIPHERALS: per-port address; port i uses slice i.
REQ-009 SHALL have port wr, input, PERIPHERALS: per-port request type; 1 = write, 0 = read.
REQ-010 SHALL have port data_in, input, DATA_WIDTH*PERIPHERALS: per-port write data.
REQ-011 SHALL have port data_in_ready, input, PERIPHERALS: per-port one-cycle request strobe.
REQ-012 SHALL have port fifo_full, output, PERIPHERALS: port i request FIFO holds FIFO_DEPTH entries.
REQ-013 SHALL have port overflow, output, PERIPHERALS: sticky; set when a strobe on port i is dropped.
REQ-014 SHALL have port data_out, output, DATA_WIDTH: shared read-data bus.
REQ-015 SHALL have port data_out_ready, output, PERIPHERALS: one-hot, one-cycle; marks the port owning data_out.

Function
REQ-016 SHALL push {wr, address, data_in} for port i at a rising edge where data_in_ready[i]=1 and fifo_full[i]=0.
REQ-017 SHALL drop the strobe when fifo_full[i]=1 at that edge, even if a pop occurs on the same edge, and set overflow[i].
REQ-018 SHALL derive fifo_full[i] from the registered occupancy count (count == FIFO_DEPTH); no combinational path from inputs.
REQ-019 SHALL grant at most one non-empty FIFO per cycle and pop it on the same edge; total throughput is one request per clock.
REQ-020 SHALL, in ARB_MODE 0, grant the first non-empty port searching upward from last_grant+1 modulo PERIPHERALS.
REQ-021 SHALL update last_grant only on cycles with a grant.
REQ-022 SHALL, in ARB_MODE 1, always grant the lowest-index non-empty port.
REQ-023 SHALL register the granted entry plus port id into an issue stage at the grant edge.
REQ-024 SHALL, at the next edge, perform the write to the internal memory when issue wr=1; no data_out_ready is produced for writes.
REQ-025 SHALL, when issue wr=0, register mem[address] into data_out and assert data_out_ready[id] for exactly one cycle.
REQ-026 SHALL have an uncontended read latency of 3 edges: strobe sampled at E0, granted at E1, data_out_ready high after E2.
REQ-027 SHALL preserve request order per port, so a read after a write on the same port returns the written data.
REQ-028 SHALL, for a same-address write and read issued on consecutive cycles from different ports, return the new data for the later read.
REQ-029 SHALL hold data_out at its last read value while data_out_ready is all-zero.

Reset
REQ-030 SHALL, while reset_n=0, force fifo_full=0, overflow=0, data_out=0, data_out_ready=0, all FIFOs empty, issue stage invalid, last_grant=PERIPHERALS-1.
REQ-031 SHALL, on reset mid-operation, discard queued and in-flight requests without producing any response; memory contents are not cleared.

Structure
REQ-032 SHALL take ARB_ROUND_ROBIN=0 and ARB_FIXED=1 from the shared mem_arb_pkg definitions, together with the request-entry width function.
REQ-033 SHALL instantiate sub-module arb_request_fifo (synchronous FIFO providing count, full, empty, push, pop) once per port.

Verification
REQ-034 SHALL test reset then a single read: port0 reads addr 0x0010 holding 0xA5 -> data_out=0xA5 with data_out_ready=2'b01, 3 edges after the strobe.
REQ-035 SHALL test write-then-read: port1 writes 0x3C to 0x1FFF, then reads it -> data_out=0x3C, data_out_ready=2'b10.
REQ-036 SHALL test round-robin: both ports strobe reads every cycle for 8 cycles -> responses alternate port0, port1, port0, ...
REQ-037 SHALL test fixed priority: with ARB_MODE=1, both ports strobe reads -> port1 responds only after port0 FIFO drains.
REQ-038 SHALL test overflow: FIFO_DEPTH=4, port1 strobes 5 reads while port0 saturates in fixed mode -> fifo_full[1]=1, 5th request dropped, overflow[1]=1, exactly 4 responses.
REQ-039 SHALL test mid-operation reset: reset_n pulsed low with 3 queued reads -> no data_out_ready afterward, all outputs 0, prior memory data still readable.
